ppm4_symbol_decoder: RTL and testbench

- Serial 4-PPM demodulator: recovers one 2-bit symbol from each 8-cycle frame of the oversampled line Din.
- Each symbol has 4 slots of SLOT_CYCLES clk16 cycles. The symbol value is the index of the slot whose last cycle carries a single active-low chip.
- Sits after the line synchronizer and preamble detector. The upstream framing FSM drives `state` high while payload symbols are being received.
- Delivers the decoded symbol plus a status bit on data_3bits_out, with a one-cycle finish2bits_out strobe per symbol.

---
 rtl/ppm_pkg.sv | 14 +
 rtl/ppm_frame_counter.sv | 30 +++
 rtl/ppm4_symbol_decoder.sv | 110 +++++++++++
 tb/tb_ppm4_symbol_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// rtl/ppm_pkg.sv - shared constants and output word type for the 4-PPM symbol decoder
package ppm_pkg;

    localparam int PPM_SLOTS = 4;
    localparam int SYM_BITS  = 2;
    localparam int ERR_BIT   = 2;

    // Output word as delivered on data_3bits_out: {err, sym[1:0]}
    typedef struct packed {
        logic                err;
        logic [SYM_BITS-1:0] sym;
    } ppm_word_t;

endpackage

// File: rtl/ppm_frame_counter.sv
// rtl/ppm_frame_counter.sv - frame position counter with enable, abort clear and frame-end pulse
module ppm_frame_counter #(
    parameter int SLOT_CYCLES = 2,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] pos,
    output logic             frame_end
);
    import ppm_pkg::*;

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(PPM_SLOTS * SLOT_CYCLES - 1);

    // Frame end is the last counting cycle; dropping en on that cycle aborts instead
    assign frame_end = en && (pos == LAST_POS);

    // Count while enabled, wrap at frame end, hold at zero while idle so frames align to en rising
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
        end else if (!en || frame_end) begin
            pos <= '0;
        end else begin
            pos <= pos + 1'b1;
        end
    end

endmodule

// File: rtl/ppm4_symbol_decoder.sv
// rtl/ppm4_symbol_decoder.sv - 4-PPM symbol demodulator; PPM_ERR_CHECK_EN enables chip-count/alignment error flag
module ppm4_symbol_decoder #(
    parameter int SLOT_CYCLES = 2,
    parameter int CNT_W       = 3
) (
    input  logic       clk16,
    input  logic       rst_n,
    input  logic       Din,
    input  logic       state,
    output logic [2:0] data_3bits_out,
    output logic       finish2bits_out
);
    import ppm_pkg::*;

    logic [CNT_W-1:0]    pos;
    logic                frame_end;
    logic [CNT_W-1:0]    pos_div;
    logic [CNT_W-1:0]    pos_mod;
    logic [SYM_BITS-1:0] cur_slot;
    logic                cur_low;
    logic [SYM_BITS-1:0] slot_r;
    logic [SYM_BITS-1:0] nxt_slot;
    logic                err_c;
    ppm_word_t           data_q;
    logic                finish_q;

    ppm_frame_counter #(
        .SLOT_CYCLES(SLOT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_frame_counter (
        .clk      (clk16),
        .rst      (rst_n),
        .en       (state),
        .pos      (pos),
        .frame_end(frame_end)
    );

    assign pos_div  = pos / CNT_W'(SLOT_CYCLES);
    assign pos_mod  = pos % CNT_W'(SLOT_CYCLES);
    assign cur_slot = pos_div[SYM_BITS-1:0];
    assign cur_low  = state && !Din;

`ifdef PPM_ERR_CHECK_EN
    logic [1:0] low_cnt;
    logic [1:0] nxt_cnt;
    logic       edge_r;
    logic       nxt_edge;
    logic       cur_edge;

    assign cur_edge = (pos_mod == CNT_W'(SLOT_CYCLES - 1));

    // Fold the current sample in so the final-position chip counts; the first chip owns slot/edge
    always_comb begin
        nxt_slot = slot_r;
        nxt_edge = edge_r;
        nxt_cnt  = low_cnt;
        if (cur_low) begin
            if (low_cnt == 2'd0) begin
                nxt_slot = cur_slot;
                nxt_edge = cur_edge;
            end
            if (low_cnt != 2'd2) begin
                nxt_cnt = low_cnt + 2'd1;
            end
        end
        err_c = (nxt_cnt == 2'd0) || (nxt_cnt == 2'd2) || !nxt_edge;
    end

    // Chip count and alignment capture, cleared between frames and on abort
    always_ff @(posedge clk16) begin
        if (rst_n || frame_end || !state) begin
            low_cnt <= 2'd0;
            edge_r  <= 1'b0;
        end else begin
            low_cnt <= nxt_cnt;
            edge_r  <= nxt_edge;
        end
    end
`else
    // Without error checking the last chip of the frame wins
    always_comb begin
        nxt_slot = cur_low ? cur_slot : slot_r;
        err_c    = 1'b0;
    end
`endif

    // Slot capture and symbol delivery; frame end latches the word and strobes for one cycle
    always_ff @(posedge clk16) begin
        if (rst_n) begin
            slot_r   <= '0;
            data_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            finish_q <= frame_end;
            if (frame_end) begin
                data_q.err <= err_c;
                data_q.sym <= nxt_slot;
                slot_r     <= '0;
            end else if (state) begin
                slot_r <= nxt_slot;
            end else begin
                slot_r <= '0;
            end
        end
    end

    assign data_3bits_out  = data_q;
    assign finish2bits_out = finish_q;

endmodule

// File: tb/tb_ppm4_symbol_decoder.sv
// tb/tb_ppm4_symbol_decoder.sv - randomized self-checking bench for ppm4_symbol_decoder with frame-level model
module tb_ppm4_symbol_decoder;

    localparam int SC = 2;
    localparam int FRAME = 4 * SC;

    logic       clk16 = 1'b0;
    logic       rst_n = 1'b0;
    logic       Din   = 1'b1;
    logic       state = 1'b0;
    logic [2:0] data_3bits_out;
    logic       finish2bits_out;

    int tests  = 0;
    int failed = 0;

    // Reference model state: position in frame and list of chip positions seen
    int         mpos = 0;
    int         lows[$];
    logic [2:0] exp_data = 3'b000;
    logic       exp_fin  = 1'b0;

    ppm4_symbol_decoder dut (
        .clk16          (clk16),
        .rst_n          (rst_n),
        .Din            (Din),
        .state          (state),
        .data_3bits_out (data_3bits_out),
        .finish2bits_out(finish2bits_out)
    );

    always #5 clk16 = ~clk16;

    function automatic logic [2:0] decode(input int chips[$]);
        logic [2:0] w;
`ifdef PPM_ERR_CHECK_EN
        if (chips.size() == 0) begin
            w = 3'b100;
        end else begin
            w[1:0] = 2'(chips[0] / SC);
            w[2]   = (chips.size() >= 2) || ((chips[0] % SC) != SC - 1);
        end
`else
        if (chips.size() == 0) w = 3'b000;
        else w = {1'b0, 2'(chips[chips.size()-1] / SC)};
`endif
        return w;
    endfunction

    // Drive one cycle of stimulus and advance the model to what the outputs must show after the edge
    task automatic tick(input logic d, input logic s);
        @(negedge clk16);
        Din   = d;
        state = s;
        @(posedge clk16);
        #1;
        if (!s) begin
            mpos = 0;
            lows.delete();
            exp_fin = 1'b0;
        end else begin
            if (!d) lows.push_back(mpos);
            if (mpos == FRAME - 1) begin
                exp_data = decode(lows);
                exp_fin  = 1'b1;
                lows.delete();
                mpos = 0;
            end else begin
                mpos++;
                exp_fin = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) tick(1'b1, 1'b0);
        rst_n = 1'b0;
        exp_data = 3'b000;
        tests++;
        if (data_3bits_out !== 3'b000 || finish2bits_out !== 1'b0) begin
            failed++;
            $display("FAIL reset: data=%b fin=%b required data=000 fin=0", data_3bits_out, finish2bits_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick($urandom_range(0, 1), 1'b0);
            tests++;
            if (data_3bits_out !== 3'b000 || finish2bits_out !== 1'b0) begin
                failed++;
                $display("FAIL reset_idle: data=%b fin=%b required data=000 fin=0", data_3bits_out, finish2bits_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        int strobe_cycles[$];
        int cyc = 0;
        logic [2:0] got[$];
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < FRAME; p++) begin
                tick(!(p == 2 * f + 1), 1'b1);
                cyc++;
                tests++;
                if (finish2bits_out !== exp_fin || data_3bits_out !== exp_data) begin
                    failed++;
                    $display("FAIL b2b_cycle: fin=%b data=%b required fin=%b data=%b", finish2bits_out, data_3bits_out, exp_fin, exp_data);
                end
                if (finish2bits_out === 1'b1) begin
                    strobe_cycles.push_back(cyc);
                    got.push_back(data_3bits_out);
                end
            end
        end
        tests++;
        if (got.size() != 4) begin
            failed++;
            $display("FAIL b2b_count: strobes=%0d required 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (got[i] !== 3'(i)) begin
                    failed++;
                    $display("FAIL b2b_symbol%0d: data=%b required %b", i, got[i], 3'(i));
                end
                if (i > 0) begin
                    tests++;
                    if (strobe_cycles[i] - strobe_cycles[i-1] != FRAME) begin
                        failed++;
                        $display("FAIL b2b_spacing: gap=%0d required %0d", strobe_cycles[i] - strobe_cycles[i-1], FRAME);
                    end
                end
            end
        end
    endtask

    // One frame with chips at the marked positions, then compare the strobed word to a fixed value
    task automatic directed_frame(input logic [FRAME-1:0] chips, input logic [2:0] want, input string name);
        for (int p = 0; p < FRAME; p++) tick(!chips[p], 1'b1);
        tests++;
        if (finish2bits_out !== 1'b1 || data_3bits_out !== want) begin
            failed++;
            $display("FAIL %s: fin=%b data=%b required fin=1 data=%b", name, finish2bits_out, data_3bits_out, want);
        end
    endtask

    task automatic test_no_chip();
`ifdef PPM_ERR_CHECK_EN
        directed_frame(8'b0000_0000, 3'b100, "no_chip");
`else
        directed_frame(8'b0000_0000, 3'b000, "no_chip");
`endif
    endtask

    task automatic test_double_chip();
`ifdef PPM_ERR_CHECK_EN
        directed_frame(8'b0010_0010, 3'b100, "double_chip");
`else
        directed_frame(8'b0010_0010, 3'b010, "double_chip");
`endif
    endtask

    task automatic test_misaligned();
`ifdef PPM_ERR_CHECK_EN
        directed_frame(8'b0000_0100, 3'b101, "misaligned");
`else
        directed_frame(8'b0000_0100, 3'b001, "misaligned");
`endif
    endtask

    task automatic test_abort();
        logic [2:0] prev;
        directed_frame(8'b1000_0000, 3'b011, "abort_setup");
        prev = data_3bits_out;
        for (int p = 0; p < 4; p++) tick(!(p == 3), 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            tests++;
            if (finish2bits_out !== 1'b0 || data_3bits_out !== prev) begin
                failed++;
                $display("FAIL abort_hold: fin=%b data=%b required fin=0 data=%b", finish2bits_out, data_3bits_out, prev);
            end
        end
        directed_frame(8'b0010_0000, 3'b010, "abort_restart");
    endtask

    task automatic test_random();
        for (int f = 0; f < 60; f++) begin
            int nchips = $urandom_range(0, 3);
            logic [FRAME-1:0] pat = '0;
            int abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, FRAME - 1) : FRAME;
            for (int k = 0; k < nchips; k++) pat[$urandom_range(0, FRAME - 1)] = 1'b1;
            if ($urandom_range(0, 1) == 1) pat = FRAME'(1) << (SC * $urandom_range(0, 3) + SC - 1);
            for (int p = 0; p < FRAME; p++) begin
                tick(!pat[p], (p < abort_at));
                tests++;
                if (finish2bits_out !== exp_fin || data_3bits_out !== exp_data) begin
                    failed++;
                    $display("FAIL random_f%0d_p%0d: fin=%b data=%b required fin=%b data=%b", f, p, finish2bits_out, data_3bits_out, exp_fin, exp_data);
                end
            end
            if ($urandom_range(0, 3) == 0) tick(1'b1, 1'b0);
        end
        rst_n = 1'b1;
        tick(1'b0, 1'b1);
        rst_n = 1'b0;
        exp_data = 3'b000;
        exp_fin  = 1'b0;
        mpos = 0;
        lows.delete();
        tests++;
        if (finish2bits_out !== 1'b0 || data_3bits_out !== 3'b000) begin
            failed++;
            $display("FAIL reset_mid: fin=%b data=%b required fin=0 data=000", finish2bits_out, data_3bits_out);
        end
        tick(1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        tick(1'b1, 1'b0);
        test_no_chip();
        test_double_chip();
        test_misaligned();
        tick(1'b1, 1'b0);
        test_abort();
        tick(1'b1, 1'b0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
